// File: rtl/clm_stream_host.sv
// Streaming front end for the CLM block cipher core: gathers 32-bit words into
// key/plaintext, starts the core, waits with a timeout and streams the ciphertext out.
module clm_stream_host #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           s_valid,
    output logic           s_ready,
    input  logic [31:0]    s_data,
    input  logic           s_key,
    output logic [0:127]   plaintext,
    output logic [0:127]   key,
    output logic           drdy_i,
    input  logic [0:127]   ciphertext,
    input  logic           drdy_o,
    output logic           m_valid,
    input  logic           m_ready,
    output logic [31:0]    m_data,
    output logic           busy,
    output logic           err
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT,
        DRAIN
    } state_t;

    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

    state_t       state;
    logic [0:127] key_r;
    logic [0:127] pt_r;
    logic [0:127] ct_r;
    logic [15:0]  timer;
    logic [2:0]   idx;
    logic         has_key;
    logic         err_r;

    logic         accept;
    logic         last_word;
    logic         to_key;
    logic [6:0]   word_base;

    assign accept    = s_valid && s_ready;
    assign last_word = has_key ? (idx == 3'd7) : (idx == 3'd3);
    // A keyed frame fills key words first (idx 0-3), then plaintext (idx 4-7).
    assign to_key    = has_key && !idx[2];
    assign word_base = {idx[1:0], 5'd0};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            key_r   <= '0;
            pt_r    <= '0;
            ct_r    <= '0;
            timer   <= '0;
            idx     <= '0;
            has_key <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (s_key) begin
                            key_r[0 +: 32] <= s_data;
                        end else begin
                            pt_r[0 +: 32] <= s_data;
                        end
                        has_key <= s_key;
                        idx     <= 3'd1;
                        err_r   <= 1'b0;
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        if (to_key) begin
                            key_r[word_base +: 32] <= s_data;
                        end else begin
                            pt_r[word_base +: 32] <= s_data;
                        end
                        idx <= idx + 3'd1;
                        if (last_word) begin
                            state <= START;
                        end
                    end
                end
                START: begin
                    timer <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    // A result arriving on the final allowed cycle still wins over the timeout.
                    if (drdy_o) begin
                        ct_r  <= ciphertext;
                        idx   <= 3'd0;
                        state <= DRAIN;
                    end else if (timer == TIMER_LAST) begin
                        err_r <= 1'b1;
                        state <= IDLE;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                DRAIN: begin
                    if (m_ready) begin
                        idx <= idx + 3'd1;
                        if (idx[1:0] == 2'd3) begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign s_ready   = (state == IDLE) || (state == LOAD);
    assign drdy_i    = (state == START);
    assign m_valid   = (state == DRAIN);
    assign busy      = (state != IDLE);
    assign err       = err_r;
    assign plaintext = pt_r;
    assign key       = key_r;
    assign m_data    = (state == DRAIN) ? ct_r[word_base +: 32] : 32'd0;

endmodule
